// File: rtl/hero_beat_packer.sv
// hero_beat_packer: per-channel beat packing into wide words with round-robin output arbitration.
module hero_beat_packer #(
    parameter int NUM_CH = 2,
    parameter int BEATS  = 4,
    parameter int DATA_W = 36,
    localparam int CW  = $clog2(BEATS + 1),
    localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*2-1:0]     in_cycle_type,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BEATS*DATA_W-1:0] out_data,
    output logic [CW-1:0]           out_count,
    output logic                    out_last,
    output logic [CHW-1:0]          out_ch,
    output logic [NUM_CH-1:0]       err
);
    typedef enum logic {FILL, HOLD} state_t;

    state_t            st   [NUM_CH];
    state_t            st_n [NUM_CH];
    logic [DATA_W-1:0] mem  [NUM_CH][BEATS];
    logic [CW-1:0]     cnt  [NUM_CH];
    logic [NUM_CH-1:0] last, acc, rel, hold;
    logic [CHW-1:0]    rr_ptr, sel, found_idx, lock_idx;
    logic              lock;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            hold[c] = st[c] == HOLD;
            acc[c]  = !hold[c] && (in_cycle_type[2*c +: 2] == 2'd1 || in_cycle_type[2*c +: 2] == 2'd2);
        end
    end

    // Descending scan so the last hit is the first HOLD channel at or after rr_ptr.
    always_comb begin
        found_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            for (int c = 0; c < NUM_CH; c++)
                if (hold[c] && (int'(rr_ptr) + i) % NUM_CH == c) found_idx = CHW'(c);
        sel = lock ? lock_idx : found_idx;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            rel[c]  = hold[c] && out_ready && sel == CHW'(c);
            st_n[c] = rel[c] ? FILL :
                      (acc[c] && (in_cycle_type[2*c+1] || cnt[c] == CW'(BEATS - 1))) ? HOLD : st[c];
        end
    end

    assign in_ready  = ~hold;
    assign out_valid = |hold;

    // Unwritten slots stay zero because buffers are cleared on release and reset.
    always_comb begin
        out_data  = '0;
        out_count = '0;
        out_last  = 1'b0;
        out_ch    = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (hold[c] && sel == CHW'(c)) begin
                for (int s = 0; s < BEATS; s++) out_data[s*DATA_W +: DATA_W] = mem[c][s];
                out_count = cnt[c];
                out_last  = last[c];
                out_ch    = sel;
            end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st[c]  <= FILL;
                cnt[c] <= '0;
                for (int s = 0; s < BEATS; s++) mem[c][s] <= '0;
            end
            last     <= '0;
            err      <= '0;
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                st[c] <= st_n[c];
                if (rel[c]) begin
                    cnt[c]  <= '0;
                    last[c] <= 1'b0;
                    for (int s = 0; s < BEATS; s++) mem[c][s] <= '0;
                end else if (acc[c]) begin
                    for (int s = 0; s < BEATS; s++)
                        if (cnt[c] == CW'(s)) mem[c][s] <= in_data[c*DATA_W +: DATA_W];
                    cnt[c]  <= cnt[c] + CW'(1);
                    last[c] <= in_cycle_type[2*c+1];
                end
                if (!hold[c] && in_cycle_type[2*c +: 2] == 2'd3) err[c] <= 1'b1;
            end
            if (out_valid && out_ready) rr_ptr <= sel == CHW'(NUM_CH - 1) ? '0 : sel + CHW'(1);
            lock     <= out_valid && !out_ready;
            lock_idx <= sel;
        end
    end
endmodule

// File: tb/tb_hero_beat_packer.sv
// tb_hero_beat_packer: scoreboard bench with a queue-based packing model and round-robin grant model.
module tb_hero_beat_packer;
    localparam int NCH = 2;
    localparam int NB  = 4;
    localparam int DW  = 36;

    typedef struct {
        logic [0:0]       ch;
        logic [NB*DW-1:0] data;
        logic [2:0]       cnt;
        logic             last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [2*NCH-1:0]   in_cycle_type = '0;
    logic [NCH*DW-1:0]  in_data = '0;
    logic [NCH-1:0]     in_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [NB*DW-1:0]   out_data;
    logic [2:0]         out_count;
    logic               out_last;
    logic [0:0]         out_ch;
    logic [NCH-1:0]     err;

    logic [1:0]  c1_type = 2'd0;
    logic [35:0] c1_data = '0;
    logic        c1_ready, c1_valid, c1_last, c1_err;
    logic [71:0] c1_odata;
    logic [1:0]  c1_count;
    logic [0:0]  c1_ch;

    int n_checks = 0;
    int n_err = 0;

    logic [DW-1:0] m_word [NCH][$];
    logic [NCH-1:0] m_hold, m_last, m_err;
    int   m_rr, m_g;
    logic m_lock;
    exp_t exp_q[$];

    hero_beat_packer #(.NUM_CH(NCH), .BEATS(NB), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .in_cycle_type(in_cycle_type), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_last(out_last),
        .out_ch(out_ch), .err(err));

    hero_beat_packer #(.NUM_CH(1), .BEATS(2), .DATA_W(36)) dut1 (
        .clk(clk), .rst(rst), .in_cycle_type(c1_type), .in_data(c1_data),
        .in_ready(c1_ready), .out_valid(c1_valid), .out_ready(1'b1),
        .out_data(c1_odata), .out_count(c1_count), .out_last(c1_last),
        .out_ch(c1_ch), .err(c1_err));

    always #5 clk = ~clk;

    function automatic exp_t mk(input int c);
        exp_t e;
        e.ch   = 1'(c);
        e.data = '0;
        foreach (m_word[c][i]) e.data[i*DW +: DW] = m_word[c][i];
        e.cnt  = 3'(m_word[c].size());
        e.last = m_last[c];
        return e;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) m_word[c].delete();
        m_hold = '0; m_last = '0; m_err = '0; m_rr = 0; m_g = 0; m_lock = 1'b0;
        exp_q.delete();
    endtask

    // One cycle of stimulus; the model advances in the same order the hardware sees it.
    task automatic step(input logic [2*NCH-1:0] ty, input logic [NCH*DW-1:0] d, input logic ordy);
        int c;
        logic [1:0] t;
        @(negedge clk); #1;
        n_checks++;
        if (in_ready !== ~m_hold || err !== m_err) begin
            n_err++;
            $display("FAIL ready_err got in_ready=%b err=%b required in_ready=%b err=%b", in_ready, err, ~m_hold, m_err);
        end
        if (!m_lock) begin
            for (int i = 0; i < NCH; i++) begin
                c = (m_rr + i) % NCH;
                if (!m_lock && m_hold[c]) begin
                    m_lock = 1'b1;
                    m_g = c;
                    exp_q.push_back(mk(c));
                end
            end
        end
        for (int k = 0; k < NCH; k++) begin
            t = ty[2*k +: 2];
            if (!m_hold[k]) begin
                if (t == 2'd3) m_err[k] = 1'b1;
                else if (t != 2'd0) begin
                    m_word[k].push_back(d[k*DW +: DW]);
                    if (t == 2'd2 || m_word[k].size() == NB) begin
                        m_hold[k] = 1'b1;
                        m_last[k] = t == 2'd2;
                    end
                end
            end
        end
        if (m_lock && ordy) begin
            m_hold[m_g] = 1'b0;
            m_word[m_g].delete();
            m_rr = (m_g + 1) % NCH;
            m_lock = 1'b0;
        end
        in_cycle_type = ty;
        in_data = d;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        in_cycle_type = '0;
        in_data = '0;
        model_clear();
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== 3'd0 || err !== '0) begin
            n_err++;
            $display("FAIL reset_state got valid=%b count=%0d err=%b required valid=0 count=0 err=0", out_valid, out_count, err);
        end
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step('0, '0, ordy);
    endtask

    initial forever begin
        @(negedge clk); #2;
        if (!rst) begin
            n_checks++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word got ch=%0d data=%h required no word", out_ch, out_data);
                end else begin
                    if (out_ch !== exp_q[0].ch || out_data !== exp_q[0].data ||
                        out_count !== exp_q[0].cnt || out_last !== exp_q[0].last) begin
                        n_err++;
                        $display("FAIL word got ch=%0d cnt=%0d last=%b data=%h required ch=%0d cnt=%0d last=%b data=%h",
                                 out_ch, out_count, out_last, out_data,
                                 exp_q[0].ch, exp_q[0].cnt, exp_q[0].last, exp_q[0].data);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0 || out_data !== '0 || out_count !== 3'd0 || out_last !== 1'b0 || out_ch !== 1'b0) begin
                n_err++;
                $display("FAIL idle_out got valid=0 count=%0d last=%b ch=%0d data=%h required %0d pending word(s) and zero outputs",
                         out_count, out_last, out_ch, out_data, exp_q.size());
            end
        end
    end

    initial begin
        logic [2*NCH-1:0]  ty;
        logic [NCH*DW-1:0] d;
        int r, words;
        model_clear();
        do_reset();
        step({2'd0, 2'd1}, {36'h0, 36'h1}, 1'b1);
        step({2'd0, 2'd1}, {36'h0, 36'h2}, 1'b1);
        step({2'd0, 2'd2}, {36'h0, 36'h3}, 1'b1);
        idle(3, 1'b1);
        step({2'd1, 2'd0}, {36'hA, 36'h0}, 1'b1);
        step({2'd1, 2'd0}, {36'hB, 36'h0}, 1'b1);
        step({2'd1, 2'd0}, {36'hC, 36'h0}, 1'b1);
        step({2'd1, 2'd0}, {36'hD, 36'h0}, 1'b0);
        step({2'd1, 2'd0}, {36'hE, 36'h0}, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            step({2'd2, 2'd2}, {36'h22, 36'h11}, 1'b0);
            idle(3, 1'b0);
            idle(4, 1'b1);
        end
        step({2'd0, 2'd2}, {36'h0, 36'h31}, 1'b1);
        idle(2, 1'b1);
        step({2'd0, 2'd2}, {36'h0, 36'h41}, 1'b0);
        step({2'd2, 2'd0}, {36'h42, 36'h0}, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);
        step({2'd0, 2'd3}, {36'h0, 36'h5}, 1'b1);
        step({2'd0, 2'd2}, {36'h0, 36'h6}, 1'b1);
        idle(3, 1'b1);
        do_reset();
        step({2'd0, 2'd1}, {36'h0, 36'h1}, 1'b1);
        step({2'd0, 2'd1}, {36'h0, 36'h2}, 1'b1);
        do_reset();
        step({2'd0, 2'd2}, {36'h0, 36'h7}, 1'b1);
        idle(3, 1'b1);
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                r = $urandom_range(0, 19);
                ty[2*c +: 2] = r < 6 ? 2'd0 : r < 16 ? 2'd1 : r < 19 ? 2'd2 : 2'd3;
                d[c*DW +: DW] = DW'({$urandom, $urandom});
            end
            step(ty, d, $urandom_range(0, 3) != 0);
        end
        idle(8, 1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending words required 0", exp_q.size());
        end
        @(negedge clk); #1;
        c1_type = 2'd1;
        c1_data = '0;
        words = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (c1_valid) begin
                words++;
                n_checks++;
                if (c1_count !== 2'd2 || c1_last !== 1'b0 || c1_odata[71:36] !== c1_odata[35:0] + 36'd1) begin
                    n_err++;
                    $display("FAIL single_ch_word got count=%0d last=%b data=%h required count=2 last=0 consecutive beats",
                             c1_count, c1_last, c1_odata);
                end
            end
            #1 c1_data = c1_data + 36'd1;
        end
        n_checks++;
        if (words != 20) begin
            n_err++;
            $display("FAIL single_ch_rate got %0d words required 20", words);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/hero_beat_packer.md
HERO_BEAT_PACKER -- requirements
Module: hero_beat_packer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent input channels (1..8).
REQ-002 SHALL have parameter BEATS, default 4: maximum beats packed into one output word (2..16).
REQ-003 SHALL have parameter DATA_W, default 36: hero bus beat width.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_cycle_type, input, NUM_CH*2: per-channel cycle type (0 IDLE, 1 VALID, 2 DONE, 3 reserved).
REQ-007 SHALL have port in_data, input, NUM_CH*DATA_W: per-channel beat data.
REQ-008 SHALL have port in_ready, output, NUM_CH: per-channel beat acceptance.
REQ-009 SHALL have port out_valid, output, 1: packed word available.
REQ-010 SHALL have port out_ready, input, 1: downstream acceptance.
REQ-011 SHALL have port out_data, output, BEATS*DATA_W: packed beats, beat 0 in LSBs.
REQ-012 SHALL have port out_count, output, clog2(BEATS+1): number of valid beats in out_data.
REQ-013 SHALL have port out_last, output, 1: word closed by DONE (1) or by reaching BEATS (0).
REQ-014 SHALL have port out_ch, output, clog2(NUM_CH) (min 1): source channel of out_data.
REQ-015 SHALL have port err, output, NUM_CH: sticky per-channel reserved-code flag.

Function
REQ-016 Each channel SHALL run a two-state machine, FILL and HOLD, with its own beat buffer, beat counter and last flag.
REQ-017 in_ready[c] SHALL be 1 exactly when channel c is in FILL.
REQ-018 A beat SHALL be accepted when in_ready[c]=1 and in_cycle_type[c] is VALID or DONE; IDLE is never accepted and changes no state.
REQ-019 An accepted beat SHALL be written to buffer slot count[c], and count[c] SHALL increment by 1.
REQ-020 An accepted DONE beat SHALL move the channel to HOLD with last=1.
REQ-021 An accepted VALID beat filling slot BEATS-1 SHALL move the channel to HOLD with last=0.
REQ-022 Reserved code 3 in FILL SHALL be dropped, leave count unchanged, and set err[c] until reset.
REQ-023 out_valid SHALL be 1 whenever any channel is in HOLD; the earliest out_valid is the cycle after the closing beat (1-cycle latency).
REQ-024 Grant SHALL be round-robin: the first HOLD channel starting at rr_ptr, with indices increasing and wrapping.
REQ-025 While out_valid=1 and out_ready=0, the grant and all out_* values SHALL remain stable, even if more channels enter HOLD.
REQ-026 On out_valid and out_ready, the granted channel SHALL return to FILL next cycle with count=0 and a zeroed buffer, and rr_ptr SHALL become granted index+1 mod NUM_CH.
REQ-027 Buffer slots at or above count SHALL read as zero in out_data.
REQ-028 A channel released on one cycle SHALL be able to accept a beat on the following cycle, with no dead cycle beyond the release.
REQ-029 When out_valid=0, out_data, out_count, out_last and out_ch SHALL be 0.

Reset
REQ-030 While rst=1, every channel SHALL be in FILL with count=0 and a zero buffer, and rr_ptr=0, err=0, out_valid=0, all out_* zero, and in_ready all-ones after release; a packet in progress is discarded.
REQ-031 Reset SHALL take effect asynchronously; deassertion is synchronous to clk.

Verification
REQ-032 Defaults, ch0 sends VALID 0x1, VALID 0x2, DONE 0x3 on consecutive cycles, out_ready=1 -> next cycle out_valid=1, out_count=3, out_last=1, out_ch=0, out_data beat2..0=3,2,1, beat3=0.
REQ-033 ch1 sends 4 VALID beats 0xA..0xD -> out_count=4, out_last=0, in_ready[1]=0 until handshake, then 1.
REQ-034 ch0 and ch1 close in the same cycle, rr_ptr=0, out_ready low 3 cycles -> ch0 held stable, then ch0 then ch1 granted; rr_ptr ends at 0.
REQ-035 ch0 drives code 3 with data 0x5 then DONE 0x6 -> err[0]=1, out_count=1, beat0=0x6.
REQ-036 rst pulse after two VALID beats on ch0 -> out_valid=0, count cleared; a subsequent DONE 0x7 yields out_count=1.
REQ-037 NUM_CH=1, BEATS=2 configuration: back-to-back words with out_ready=1 -> no deadlock, one word every 3 cycles.
